// File: rtl/systolic_driver_pkg.sv
// rtl/systolic_driver_pkg.sv - shared state encoding, widths and helpers for the systolic array driver
package systolic_driver_pkg;

  localparam int INNER_DIM_W = 20;
  localparam int CYCLE_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_FEED    = 3'd2,
    ST_COLLECT = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // Cycle counter sticks at all-ones instead of wrapping.
  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
    return (&v) ? v : v + CYCLE_W'(1);
  endfunction

endpackage

// File: rtl/systolic_pair_join.sv
// rtl/systolic_pair_join.sv - joins the activation and weight streams so a beat moves only when both
// sides are valid and both array inputs are ready.
module systolic_pair_join (
  input  logic i_en,
  input  logic i_a_valid,
  input  logic i_b_valid,
  input  logic i_a_ready,
  input  logic i_b_ready,
  output logic o_valid,
  output logic o_src_ready
);

  logic w_both_valid;

  assign w_both_valid = i_en && i_a_valid && i_b_valid;
  assign o_valid      = w_both_valid;
  assign o_src_ready  = w_both_valid && i_a_ready && i_b_ready;

endmodule

// File: rtl/systolic_driver.sv
// rtl/systolic_driver.sv - sequences one tile through a systolic array: start, K operand beats,
// DIM result rows, then a completion response with error flag and cycle count.
module systolic_driver
  import systolic_driver_pkg::*;
#(
  parameter  int SYSTOLIC_ARRAY_DIM = 8,
  parameter  int DATA_WIDTH_BITS    = 16,
  localparam int VEC_W = SYSTOLIC_ARRAY_DIM * DATA_WIDTH_BITS,
  localparam int ROW_W = (SYSTOLIC_ARRAY_DIM > 1) ? $clog2(SYSTOLIC_ARRAY_DIM) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [INNER_DIM_W-1:0] cmd_inner_dim,
  input  logic [VEC_W-1:0]       src_act_data,
  input  logic                   src_act_valid,
  output logic                   src_act_ready,
  input  logic [VEC_W-1:0]       src_wgt_data,
  input  logic                   src_wgt_valid,
  output logic                   src_wgt_ready,
  output logic [VEC_W-1:0]       arr_act_in,
  output logic [VEC_W-1:0]       arr_wgt_in,
  output logic                   arr_act_valid,
  output logic                   arr_wgt_valid,
  input  logic                   arr_act_ready,
  input  logic                   arr_wgt_ready,
  output logic                   arr_start,
  input  logic                   arr_start_ready,
  output logic [INNER_DIM_W-1:0] arr_inner_dim,
  input  logic [VEC_W-1:0]       arr_out,
  input  logic                   arr_out_valid,
  output logic                   arr_out_ready,
  output logic [VEC_W-1:0]       res_data,
  output logic [ROW_W-1:0]       res_row,
  output logic                   res_last,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_err,
  output logic [CYCLE_W-1:0]     resp_cycles
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SYSTOLIC_ARRAY_DIM - 1);

  state_t                 r_state;
  logic                   r_cmd_ready;
  logic                   r_err;
  logic [INNER_DIM_W-1:0] r_k;
  logic [INNER_DIM_W-1:0] r_beats;
  logic [ROW_W-1:0]       r_row;
  logic [CYCLE_W-1:0]     r_cycles;

  logic w_feed;
  logic w_collect;
  logic w_pair_valid;
  logic w_beat;
  logic w_row_xfer;
  logic w_last;

  assign w_feed     = (r_state == ST_FEED);
  assign w_collect  = (r_state == ST_COLLECT);
  assign w_last     = (r_row == LAST_ROW);
  assign w_row_xfer = w_collect && arr_out_valid && res_ready;

  systolic_pair_join u_join (
    .i_en        (w_feed),
    .i_a_valid   (src_act_valid),
    .i_b_valid   (src_wgt_valid),
    .i_a_ready   (arr_act_ready),
    .i_b_ready   (arr_wgt_ready),
    .o_valid     (w_pair_valid),
    .o_src_ready (w_beat)
  );

  // Data paths are zeroed outside their phase so nothing leaks while idle or in reset.
  assign cmd_ready     = r_cmd_ready;
  assign arr_start     = (r_state == ST_START);
  assign arr_inner_dim = r_k;
  assign arr_act_valid = w_pair_valid;
  assign arr_wgt_valid = w_pair_valid;
  assign src_act_ready = w_beat;
  assign src_wgt_ready = w_beat;
  assign arr_act_in    = w_feed ? src_act_data : '0;
  assign arr_wgt_in    = w_feed ? src_wgt_data : '0;
  assign res_data      = w_collect ? arr_out : '0;
  assign res_valid     = w_collect && arr_out_valid;
  assign arr_out_ready = w_collect && res_ready;
  assign res_row       = r_row;
  assign res_last      = w_collect && w_last;
  assign resp_valid    = (r_state == ST_RESP);
  assign resp_err      = r_err;
  assign resp_cycles   = r_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_err       <= 1'b0;
      r_k         <= '0;
      r_beats     <= '0;
      r_row       <= '0;
      r_cycles    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_k         <= cmd_inner_dim;
            r_cycles    <= '0;
            r_cmd_ready <= 1'b0;
            if (cmd_inner_dim == '0) begin
              r_err   <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              r_err   <= 1'b0;
              r_state <= ST_START;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_START: begin
          r_cycles <= sat_inc(r_cycles);
          if (arr_start_ready) begin
            r_beats <= r_k;
            r_state <= ST_FEED;
          end
        end
        ST_FEED: begin
          r_cycles <= sat_inc(r_cycles);
          if (w_beat) begin
            r_beats <= r_beats - INNER_DIM_W'(1);
            if (r_beats == INNER_DIM_W'(1)) begin
              r_row   <= '0;
              r_state <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          r_cycles <= sat_inc(r_cycles);
          if (w_row_xfer) begin
            r_row <= r_row + ROW_W'(1);
            if (w_last) begin
              r_err   <= 1'b0;
              r_state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_driver.sv
// tb/tb_systolic_driver.sv - directed bench for systolic_driver with a phase model and a handshake table
module tb_systolic_driver;

  localparam int DIM = 8;
  localparam int W   = 16;
  localparam int VW  = DIM * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [19:0]   cmd_inner_dim;
  logic [VW-1:0] src_act_data;
  logic          src_act_valid;
  logic          src_act_ready;
  logic [VW-1:0] src_wgt_data;
  logic          src_wgt_valid;
  logic          src_wgt_ready;
  logic [VW-1:0] arr_act_in;
  logic [VW-1:0] arr_wgt_in;
  logic          arr_act_valid;
  logic          arr_wgt_valid;
  logic          arr_act_ready;
  logic          arr_wgt_ready;
  logic          arr_start;
  logic          arr_start_ready;
  logic [19:0]   arr_inner_dim;
  logic [VW-1:0] arr_out;
  logic          arr_out_valid;
  logic          arr_out_ready;
  logic [VW-1:0] res_data;
  logic [2:0]    res_row;
  logic          res_last;
  logic          res_valid;
  logic          res_ready;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_err;
  logic [31:0]   resp_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  systolic_driver #(.SYSTOLIC_ARRAY_DIM(DIM), .DATA_WIDTH_BITS(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_inner_dim(cmd_inner_dim),
    .src_act_data(src_act_data), .src_act_valid(src_act_valid), .src_act_ready(src_act_ready),
    .src_wgt_data(src_wgt_data), .src_wgt_valid(src_wgt_valid), .src_wgt_ready(src_wgt_ready),
    .arr_act_in(arr_act_in), .arr_wgt_in(arr_wgt_in),
    .arr_act_valid(arr_act_valid), .arr_wgt_valid(arr_wgt_valid),
    .arr_act_ready(arr_act_ready), .arr_wgt_ready(arr_wgt_ready),
    .arr_start(arr_start), .arr_start_ready(arr_start_ready), .arr_inner_dim(arr_inner_dim),
    .arr_out(arr_out), .arr_out_valid(arr_out_valid), .arr_out_ready(arr_out_ready),
    .res_data(res_data), .res_row(res_row), .res_last(res_last),
    .res_valid(res_valid), .res_ready(res_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err), .resp_cycles(resp_cycles)
  );

  typedef struct {
    logic av, wv, ar, wr;
    logic exp_v, exp_r;
  } vec_t;

  task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    cmd_valid = 0; cmd_inner_dim = '0;
    src_act_data = '0; src_act_valid = 0; src_wgt_data = '0; src_wgt_valid = 0;
    arr_act_ready = 0; arr_wgt_ready = 0; arr_start_ready = 0;
    arr_out = '0; arr_out_valid = 0; res_ready = 0; resp_ready = 0;
  endtask

  task automatic send_cmd(input logic [19:0] k);
    int n = 0;
    while (n < 20 && cmd_ready !== 1'b1) begin
      step();
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1; cmd_inner_dim = k;
    step();
    cmd_valid = 0;
  endtask

  task automatic finish_resp();
    resp_ready = 1;
    #1;
    chk("cmd_ready_in_resp", cmd_ready, 0);
    step();
    resp_ready = 0;
    chk("cmd_ready_after_resp", cmd_ready, 1);
    chk("resp_valid_after_resp", resp_valid, 0);
  endtask

  // Phases: 1=START 2=FEED 3=COLLECT 4=RESP; the model advances only from bench-driven inputs.
  task automatic run_tile(input int k, input int stall, input int wlate, input bit tog, input int exp_cyc);
    int ph = 1, left = 0, row = 0, cyc = 0, scnt = 0, fidx = 0, cidx = 0;
    int beats = 0, rows = 0, it = 0;
    bit done = 0;
    logic fe, co, rs, fire;
    while (it < 300 && !done) begin
      arr_start_ready = (ph == 1) ? (scnt >= stall) : 1'b1;
      src_act_valid = 1;
      src_wgt_valid = !(ph == 2 && fidx < wlate);
      arr_act_ready = 1; arr_wgt_ready = 1;
      src_act_data = rnd_vec(); src_wgt_data = rnd_vec();
      arr_out_valid = 1; arr_out = rnd_vec();
      res_ready = tog ? (cidx % 2 == 1) : 1'b1;
      #1;
      fe = (ph == 2); co = (ph == 3); rs = (ph == 4);
      fire = fe && src_act_valid && src_wgt_valid && arr_act_ready && arr_wgt_ready;
      chk("arr_start", arr_start, ph == 1);
      if (ph == 1) chk("arr_inner_dim", arr_inner_dim, k);
      chk("arr_act_valid", arr_act_valid, fe && src_act_valid && src_wgt_valid);
      chk("arr_wgt_valid", arr_wgt_valid, fe && src_act_valid && src_wgt_valid);
      chk("src_act_ready", src_act_ready, fire);
      chk("src_wgt_ready", src_wgt_ready, fire);
      chk("arr_act_in", arr_act_in, fe ? src_act_data : '0);
      chk("arr_wgt_in", arr_wgt_in, fe ? src_wgt_data : '0);
      chk("res_valid", res_valid, co);
      chk("arr_out_ready", arr_out_ready, co && res_ready);
      chk("res_data", res_data, co ? arr_out : '0);
      if (co) begin
        chk("res_row", res_row, row);
        chk("res_last", res_last, row == DIM - 1);
      end
      chk("resp_valid", resp_valid, rs);
      chk("cmd_ready_busy", cmd_ready, 0);
      if (rs) begin
        chk("resp_err", resp_err, 0);
        chk("resp_cycles_model", resp_cycles, cyc);
        chk("resp_cycles_const", resp_cycles, exp_cyc);
        done = 1;
      end else begin
        cyc++;
        case (ph)
          1: begin
            scnt++;
            if (arr_start_ready) begin ph = 2; left = k; end
          end
          2: begin
            fidx++;
            if (fire) begin
              beats++; left--;
              if (left == 0) begin ph = 3; row = 0; end
            end
          end
          default: begin
            cidx++;
            if (res_ready) begin
              rows++;
              if (row == DIM - 1) ph = 4;
              else row++;
            end
          end
        endcase
        step();
        it++;
      end
    end
    if (!done) chk("tile_timeout", 0, 1);
    chk("beat_count", beats, k);
    chk("row_count", rows, DIM);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vecs[8];
    int fired;
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    idle_inputs();
    rst = 1;
    src_act_valid = 1; src_wgt_valid = 1; arr_out_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_arr_start", arr_start, 0);
    chk("rst_arr_act_valid", arr_act_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_cycles", resp_cycles, 0);
    chk("rst_resp_err", resp_err, 0);
    idle_inputs();
    rst = 0;
    step();
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_arr_start", arr_start, 0);

    // K=4, everything ready: 1 start + 4 beats + 8 rows.
    send_cmd(4);
    run_tile(4, 0, 0, 0, 13);
    finish_resp();

    // K=0 answers immediately with an error and never starts the array.
    idle_inputs();
    send_cmd(0);
    chk("k0_arr_start", arr_start, 0);
    chk("k0_resp_valid", resp_valid, 1);
    chk("k0_resp_err", resp_err, 1);
    chk("k0_resp_cycles", resp_cycles, 0);
    step();
    chk("k0_resp_hold", resp_valid, 1);
    chk("k0_arr_start_hold", arr_start, 0);
    finish_resp();

    // Handshake truth table in FEED with K=3: two table beats, then the final beat.
    idle_inputs();
    send_cmd(3);
    arr_start_ready = 1;
    step();
    arr_start_ready = 0;
    fired = 0;
    for (int i = 0; i < 8; i++) begin
      src_act_valid = vecs[i].av; src_wgt_valid = vecs[i].wv;
      arr_act_ready = vecs[i].ar; arr_wgt_ready = vecs[i].wr;
      src_act_data = rnd_vec(); src_wgt_data = rnd_vec();
      #1;
      chk($sformatf("tbl%0d_act_valid", i), arr_act_valid, vecs[i].exp_v);
      chk($sformatf("tbl%0d_wgt_valid", i), arr_wgt_valid, vecs[i].exp_v);
      chk($sformatf("tbl%0d_act_ready", i), src_act_ready, vecs[i].exp_r);
      chk($sformatf("tbl%0d_wgt_ready", i), src_wgt_ready, vecs[i].exp_r);
      chk($sformatf("tbl%0d_act_data", i), arr_act_in, src_act_data);
      if (vecs[i].exp_r) fired++;
      step();
    end
    chk("tbl_fired", fired, 2);
    src_act_valid = 1; src_wgt_valid = 1; arr_act_ready = 1; arr_wgt_ready = 1;
    arr_out_valid = 1; res_ready = 0;
    #1;
    chk("tbl_last_beat", src_act_ready, 1);
    step();
    chk("tbl_no_extra_beat", arr_act_valid, 0);
    chk("tbl_collect_valid", res_valid, 1);
    chk("tbl_collect_row0", res_row, 0);
    rst = 1;
    step();
    rst = 0;
    idle_inputs();
    step();

    // Weight stream two cycles late: activation must not be consumed alone.
    send_cmd(3);
    run_tile(3, 0, 2, 0, 14);
    finish_resp();

    // arr_start_ready low for 5 cycles.
    idle_inputs();
    send_cmd(2);
    run_tile(2, 5, 0, 0, 16);
    finish_resp();

    // res_ready toggling every cycle during COLLECT.
    idle_inputs();
    send_cmd(2);
    run_tile(2, 0, 0, 1, 19);
    finish_resp();

    // Reset after 2 of 6 beats abandons the tile.
    idle_inputs();
    send_cmd(6);
    arr_start_ready = 1;
    src_act_valid = 1; src_wgt_valid = 1; arr_act_ready = 1; arr_wgt_ready = 1;
    arr_out_valid = 1; res_ready = 1; resp_ready = 1;
    step();
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("abort_beat%0d", b), src_act_ready, 1);
      step();
    end
    src_act_data = rnd_vec();
    rst = 1;
    #1;
    chk("abort_cmd_ready", cmd_ready, 0);
    chk("abort_arr_start", arr_start, 0);
    chk("abort_src_act_ready", src_act_ready, 0);
    chk("abort_src_wgt_ready", src_wgt_ready, 0);
    chk("abort_arr_act_valid", arr_act_valid, 0);
    chk("abort_arr_wgt_valid", arr_wgt_valid, 0);
    chk("abort_arr_act_in", arr_act_in, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_arr_out_ready", arr_out_ready, 0);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_arr_inner_dim", arr_inner_dim, 0);
    chk("abort_resp_cycles", resp_cycles, 0);
    step();
    rst = 0;
    step();
    chk("abort_idle_cmd_ready", cmd_ready, 1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("abort_no_resp%0d", c), resp_valid, 0);
      chk($sformatf("abort_no_feed%0d", c), arr_act_valid, 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
